// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a synchronous-read
// instruction memory (one cycle of read latency).
//
// Issues a word address every cycle, tracks which address is in flight, and
// registers the returned word into the IF/ID output register with its PC and
// a valid bit. Handles decode stalls (hold outputs, re-read the in-flight
// word), branch/jump redirects (flush, refetch from the target), and halts on
// the all-zero word that fills memory after the program.
//
// Ports:
//   Clk          rising-edge clock, shared with the instruction memory
//   Rst          asynchronous active-low reset
//   endereco     word address to the memory, sampled on the rising edge
//   instrucao    memory read data: mem[endereco sampled at previous edge]
//   stall        decode cannot accept; hold the output register
//   redirect     branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc  redirect target address
//   instr_out    IF/ID instruction
//   pc_out       address of instr_out
//   valid_out    instr_out/pc_out hold a real instruction
//   halted       fetch stopped on a zero word
module fetch_unit #(
  parameter int unsigned           ADDR_W       = 10,
  parameter int unsigned           DATA_W       = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC     = '0,
  parameter logic                  HALT_ON_ZERO = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] instrucao,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              halted
);

  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight_valid;
  logic [ADDR_W-1:0] next_addr;
  logic              issue_valid;
  logic              halt_det;

  // A zero word only halts when it is a real fetched word that would
  // otherwise be delivered this edge.
  assign halt_det = HALT_ON_ZERO && inflight_valid && (instrucao == '0) &&
                    !stall && !redirect;

  always_comb begin
    next_addr   = inflight_addr;
    issue_valid = 1'b0;
    if (redirect) begin
      next_addr   = redirect_pc;
      issue_valid = 1'b1;
    end else if (halted || halt_det) begin
      next_addr   = inflight_addr;
      issue_valid = 1'b0;
    end else if (stall) begin
      // Re-read the in-flight word so it is still on instrucao at release.
      next_addr   = inflight_addr;
      issue_valid = inflight_valid;
    end else begin
      next_addr   = inflight_valid ? inflight_addr + ADDR_W'(1) : inflight_addr;
      issue_valid = 1'b1;
    end
  end

  // While reset is held the memory must see RESET_PC whatever the inputs are.
  assign endereco = Rst ? next_addr : RESET_PC;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      inflight_addr  <= RESET_PC;
      inflight_valid <= 1'b0;
    end else begin
      inflight_addr  <= endereco;
      inflight_valid <= issue_valid;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (stall) begin
      valid_out <= valid_out;
    end else if (halt_det) begin
      valid_out <= 1'b0;
      halted    <= 1'b1;
    end else begin
      instr_out <= instrucao;
      pc_out    <= inflight_addr;
      valid_out <= inflight_valid;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Directed scenarios
// (start-up latency, stall, redirect, halt, mid-run reset, address wrap)
// followed by randomized stall/redirect/reset traffic, all compared against
// a behavioural model of the fetch stream that owns its own copy of memory.
module tb_fetch_unit;

  localparam int RST_PC = 0;
  localparam int NWORDS = 1024;

  logic        Clk;
  logic        Rst;
  logic [9:0]  endereco;
  logic [31:0] instrucao;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic [31:0] instr_out;
  logic [9:0]  pc_out;
  logic        valid_out;
  logic        halted;

  logic        w_rst;
  logic [9:0]  w_addr;
  logic [31:0] w_instr;
  logic        w_stall;
  logic        w_redirect;
  logic [9:0]  w_rpc;
  logic [31:0] w_iout;
  logic [9:0]  w_pout;
  logic        w_vout;
  logic        w_halted;

  logic [31:0] mem  [NWORDS];
  logic [31:0] wmem [NWORDS];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the word whose data arrives this cycle (address and
  // whether it was a genuine fetch), plus the visible IF/ID contents.
  int          m_pc;
  bit          m_live;
  bit          m_halt;
  bit          m_valid;
  int          m_pc_out;
  logic [31:0] m_instr;

  fetch_unit #(
    .ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0), .HALT_ON_ZERO(1'b1)
  ) dut (
    .Clk(Clk), .Rst(Rst), .endereco(endereco), .instrucao(instrucao),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .halted(halted)
  );

  fetch_unit #(
    .ADDR_W(10), .DATA_W(32), .RESET_PC(10'd1023), .HALT_ON_ZERO(1'b1)
  ) u_wrap (
    .Clk(Clk), .Rst(w_rst), .endereco(w_addr), .instrucao(w_instr),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_rpc),
    .instr_out(w_iout), .pc_out(w_pout), .valid_out(w_vout),
    .halted(w_halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read instruction memories.
  always @(posedge Clk) instrucao <= mem[endereco];
  always @(posedge Clk) w_instr   <= wmem[w_addr];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_live   = 1'b0;
    m_halt   = 1'b0;
    m_valid  = 1'b0;
    m_pc_out = 0;
    m_instr  = '0;
  endtask

  function automatic bit zero_hit(input bit st, input bit rd);
    return m_live && (mem[m_pc] == 32'd0) && !st && !rd;
  endfunction

  // Address the fetch stage should be presenting to memory right now.
  function automatic int want_addr(input bit st, input bit rd, input int rpc, input bit rst);
    if (!rst) return RST_PC;
    if (rd) return rpc;
    if (m_halt || zero_hit(st, rd) || st) return m_pc;
    if (m_live) return (m_pc + 1) % NWORDS;
    return m_pc;
  endfunction

  // Whether the address being requested now is a genuine fetch.
  function automatic bit want_live(input bit st, input bit rd);
    if (rd) return 1'b1;
    if (m_halt || zero_hit(st, rd)) return 1'b0;
    if (st) return m_live;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit st, input bit rd, input int rpc, input bit rst);
    int          nxt;
    bit          nlive;
    logic [31:0] word;
    bit          zh;
    if (!rst) begin
      model_reset();
      return;
    end
    word  = mem[m_pc];
    zh    = zero_hit(st, rd);
    nxt   = want_addr(st, rd, rpc, rst);
    nlive = want_live(st, rd);
    if (rd) begin
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (st) begin
      // decode holds the current IF/ID contents
    end else if (zh) begin
      m_valid = 1'b0;
      m_halt  = 1'b1;
    end else begin
      m_instr  = word;
      m_pc_out = m_pc;
      m_valid  = m_live;
    end
    m_pc   = nxt;
    m_live = nlive;
  endtask

  task automatic compare_outputs();
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halt));
    if (m_valid) begin
      check("pc_out", 32'(pc_out), 32'(m_pc_out));
      check("instr_out", instr_out, m_instr);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check the address
  // presented to memory, then check IF/ID just after the rising edge.
  task automatic step(input bit st, input bit rd, input int rpc, input bit rst);
    @(negedge Clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = 10'(rpc);
    Rst         = rst;
    if (!rst) model_reset();
    #1;
    check("endereco", 32'(endereco), 32'(want_addr(st, rd, rpc, rst)));
    if (!rst) compare_outputs();
    @(posedge Clk);
    model_edge(st, rd, rpc, rst);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    logic [31:0] v;
    Rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_rst = 1'b0; w_stall = 1'b0; w_redirect = 1'b0; w_rpc = '0;
    model_reset();

    mem[0] = 32'h23E01500;
    for (int i = 1; i < 22; i++) mem[i] = 32'h1000_0000 | 32'(i * 32'h111);
    mem[22] = 32'h27E618FF;
    for (int i = 23; i < 100; i++) mem[i] = 32'd0;
    for (int i = 100; i < NWORDS; i++) begin
      v = $urandom;
      if ($urandom_range(0, 15) == 0) v = 32'd0;
      else if (v == 32'd0) v = 32'd1;
      mem[i] = v;
    end
    for (int i = 0; i < NWORDS; i++) wmem[i] = 32'h8000_0000 | 32'(i);

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_addr", 32'(endereco), 32'(RST_PC));

    // Start-up latency and sequential stream
    idle();
    check("e1_valid", 32'(valid_out), 32'd0);
    idle();
    check("e2_valid", 32'(valid_out), 32'd1);
    check("e2_pc", 32'(pc_out), 32'd0);
    check("e2_instr", instr_out, 32'h23E01500);
    for (int p = 1; p <= 2; p++) begin
      idle();
      check("seq_pc", 32'(pc_out), 32'(p));
    end

    // Redirect while pc_out=2: one bubble, then the target
    step(1'b0, 1'b1, 8, 1'b1);
    check("redir_bubble", 32'(valid_out), 32'd0);
    idle();
    check("redir_pc", 32'(pc_out), 32'd8);
    check("redir_instr", instr_out, mem[8]);

    // Stall for three cycles while pc_out=4
    step(1'b0, 1'b1, 3, 1'b1);
    idle();
    idle();
    check("pre_stall_pc", 32'(pc_out), 32'd4);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 0, 1'b1);
      check("stall_hold_pc", 32'(pc_out), 32'd4);
      check("stall_hold_valid", 32'(valid_out), 32'd1);
    end
    idle();
    check("post_stall_pc5", 32'(pc_out), 32'd5);
    idle();
    check("post_stall_pc6", 32'(pc_out), 32'd6);

    // Run to the end of the program and into the zero fill
    for (int i = 0; i < 40 && !(valid_out && pc_out == 10'd22); i++) idle();
    check("last_pc", 32'(pc_out), 32'd22);
    check("last_instr", instr_out, 32'h27E618FF);
    idle();
    check("halt_set", 32'(halted), 32'd1);
    check("halt_valid", 32'(valid_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("halt_addr", 32'(endereco), 32'd23);
      check("halt_stays", 32'(halted), 32'd1);
    end

    // Redirect out of halt
    step(1'b0, 1'b1, 8, 1'b1);
    check("unhalt_clear", 32'(halted), 32'd0);
    check("unhalt_bubble", 32'(valid_out), 32'd0);
    idle();
    check("unhalt_pc", 32'(pc_out), 32'd8);
    check("unhalt_instr", instr_out, mem[8]);

    // Stall and redirect together: redirect wins
    step(1'b1, 1'b1, 12, 1'b1);
    check("stall_redir_valid", 32'(valid_out), 32'd0);
    idle();
    check("stall_redir_pc", 32'(pc_out), 32'd12);

    // Reset pulsed mid-run while pc_out=5
    step(1'b0, 1'b1, 5, 1'b1);
    idle();
    check("pre_rst_pc", 32'(pc_out), 32'd5);
    step(1'b0, 1'b0, 0, 1'b0);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_pc", 32'(pc_out), 32'd0);
    idle();
    check("restart_e1", 32'(valid_out), 32'd0);
    idle();
    check("restart_e2_valid", 32'(valid_out), 32'd1);
    check("restart_e2_pc", 32'(pc_out), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           int'($urandom_range(0, NWORDS - 1)), !($urandom_range(0, 199) == 0));
    end
    step(1'b0, 1'b0, 0, 1'b1);

    // Address wrap from RESET_PC=1023
    @(negedge Clk);
    w_rst = 1'b1;
    @(posedge Clk); #1;
    check("wrap_e1_valid", 32'(w_vout), 32'd0);
    @(posedge Clk); #1;
    check("wrap_e2_valid", 32'(w_vout), 32'd1);
    check("wrap_e2_pc", 32'(w_pout), 32'd1023);
    check("wrap_e2_instr", w_iout, wmem[1023]);
    @(posedge Clk); #1;
    check("wrap_e3_pc", 32'(w_pout), 32'd0);
    check("wrap_e3_instr", w_iout, wmem[0]);
    check("wrap_halted", 32'(w_halted), 32'd0);
    @(negedge Clk);
    w_stall = 1'b1; w_redirect = 1'b1; w_rpc = 10'd500;
    @(posedge Clk); #1;
    check("wrap_sr_valid", 32'(w_vout), 32'd0);
    @(negedge Clk);
    w_stall = 1'b0; w_redirect = 1'b0;
    @(posedge Clk); #1;
    check("wrap_sr_pc", 32'(w_pout), 32'd500);
    check("wrap_sr_instr", w_iout, wmem[500]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
